// File: rtl/seq_mult_shift_add.sv
// seq_mult_shift_add
// Shift-and-add control/datapath stage of a sequential unsigned multiplier.
// It strobes the upstream operand registers when a multiply is requested,
// captures their outputs one cycle later, then runs WIDTH add/shift
// iterations and publishes the 2*WIDTH-bit product with a one-cycle done pulse.
//
// Ports:
//   clk      system clock, rising edge active
//   rst_n    asynchronous active-low reset
//   start    multiply request, honoured only while idle
//   mcand    multiplicand from the upstream operand register
//   mplier   multiplier from the upstream operand register
//   ld_op    load strobe for both upstream operand registers
//   busy     high whenever the engine is not idle
//   done     one-cycle pulse, product is valid
//   product  registered result, held until the next completion
module seq_mult_shift_add #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               ld_op,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             c;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] q_shift;

  // One add/shift step. The adder is WIDTH+1 bits wide so the carry out of
  // A+M survives and becomes the MSB of A after the right shift. Zero is
  // shifted into C, so the step result is already the final value and the
  // product can be captured on the last iteration with no extra cycle.
  always_comb begin
    sum     = {c, a} + (q[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    a_shift = sum[WIDTH:1];
    q_shift = {sum[0], q[WIDTH-1:1]};
  end

  // Next-state and control outputs. ld_op follows start combinationally
  // while idle so the operand registers load on the same edge that accepts
  // the request; it is gated with rst_n so nothing loads during reset.
  always_comb begin
    state_next = state;
    ld_op      = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        ld_op = start & rst_n;
        if (start) state_next = LOAD;
      end
      LOAD: state_next = CALC;
      CALC: if (count == CW'(1)) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath registers. Operands are only sampled in LOAD, one cycle after
  // the upstream registers were strobed, so they are stable by then.
  // A reset clears the product too, so an aborted operation leaves no result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      q       <= '0;
      m       <= '0;
      c       <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        LOAD: begin
          m     <= mcand;
          q     <= mplier;
          a     <= '0;
          c     <= 1'b0;
          count <= CW'(WIDTH);
        end
        CALC: begin
          a     <= a_shift;
          q     <= q_shift;
          c     <= 1'b0;
          count <= count - CW'(1);
          if (count == CW'(1)) product <= {a_shift, q_shift};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// tb_seq_mult_shift_add
// Directed bench for seq_mult_shift_add with a model of the two upstream
// operand registers. Expected products are queued when a request is issued;
// a monitor on the falling edge pops and compares on every done pulse.
module tb_seq_mult_shift_add;

  localparam int WIDTH = 4;
  localparam int CW    = 3;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   in_mcand;
  logic [WIDTH-1:0]   in_mplier;
  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic               ld_op;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int compared   = 0;
  int mismatched = 0;
  int done_count = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  seq_mult_shift_add #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand_reg),
    .mplier  (mplier_reg),
    .ld_op   (ld_op),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream parallel-load operand registers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else if (ld_op) begin
      mcand_reg  <= in_mcand;
      mplier_reg <= in_mplier;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        checkOutput("product", int'(product), int'(exp_q.pop_front()));
      end
    end
  end

  // Waits for done, sampling 1 time unit after each rising edge.
  task automatic waitDone(output int cycles);
    cycles = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (done === 1'b1) return;
    end
    checkOutput("done_timeout", 0, 1);
  endtask

  // Issues one multiply from IDLE and checks handshake timing around it.
  task automatic applyStimulus(input int a, input int b, input int expected);
    int lat;
    in_mcand  = WIDTH'(a);
    in_mplier = WIDTH'(b);
    start     = 1'b1;
    exp_q.push_back((2*WIDTH)'(expected));
    #1;
    checkOutput("ld_op_at_E0", int'(ld_op), 1);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    checkOutput("busy_after_E0", int'(busy), 1);
    checkOutput("ld_op_while_busy", int'(ld_op), 0);
    waitDone(lat);
    checkOutput("done_latency", lat, WIDTH + 1);
    checkOutput("busy_in_done", int'(busy), 1);
    @(posedge clk); #1;
    checkOutput("busy_after_E6", int'(busy), 0);
    checkOutput("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, t1, t2, dc;
    rst_n     = 1'b0;
    start     = 1'b1;
    in_mcand  = '0;
    in_mplier = '0;
    #13;
    checkOutput("reset_ld_op_gated", int'(ld_op), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_product", int'(product), 0);
    start = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_ld_op", int'(ld_op), 0);

    $display("[TB] basic products");
    applyStimulus(13, 11, 143);
    applyStimulus(15, 15, 225);
    applyStimulus(0, 9, 0);
    applyStimulus(1, 15, 15);

    $display("[TB] start pulses while busy");
    dc = done_count;
    in_mcand  = 4'd3;
    in_mplier = 4'd5;
    start     = 1'b1;
    exp_q.push_back(8'd15);
    @(posedge clk); #1;
    start     = 1'b0;
    in_mcand  = 4'd9;
    in_mplier = 4'd9;
    @(posedge clk); #1;
    start = 1'b1;
    #1 checkOutput("ld_op_busy_E2", int'(ld_op), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    #1 checkOutput("ld_op_busy_E4", int'(ld_op), 0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("single_done_pulse", done_count - dc, 1);
    checkOutput("upstream_mcand_kept", int'(mcand_reg), 3);
    checkOutput("upstream_mplier_kept", int'(mplier_reg), 5);

    $display("[TB] start held high");
    in_mcand  = 4'd7;
    in_mplier = 4'd6;
    start     = 1'b1;
    exp_q.push_back(8'd42);
    exp_q.push_back(8'd18);
    @(posedge clk); #1;
    in_mcand  = 4'd2;
    in_mplier = 4'd9;
    t = 0; t1 = -1; t2 = -1;
    for (int i = 0; i < 40 && t2 < 0; i++) begin
      @(posedge clk); #1;
      t++;
      if (done === 1'b1) begin
        if (t1 < 0) t1 = t;
        else        t2 = t;
      end
    end
    start = 1'b0;
    checkOutput("first_done_cycle", t1, WIDTH + 1);
    checkOutput("done_spacing", t2 - t1, WIDTH + 3);
    @(posedge clk); #1;

    $display("[TB] asynchronous reset mid-operation");
    in_mcand  = 4'd6;
    in_mplier = 4'd7;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_product", int'(product), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    dc = done_count;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("no_done_after_abort", done_count - dc, 0);
    checkOutput("idle_after_abort", int'(busy), 0);
    applyStimulus(5, 5, 25);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
